// File: rtl/pipe_pkg.sv
// Shared PIPE control definitions: power states, RxStatus codes and responder FSM states.
// Build option PIPE_RATE_ACK_EN adds the RATE_CHG state and the Gen1 rate code.
package pipe_pkg;

    localparam logic [3:0] P0  = 4'd0;
    localparam logic [3:0] P0S = 4'd1;
    localparam logic [3:0] P1  = 4'd2;
    localparam logic [3:0] P2  = 4'd3;

    localparam logic [2:0] RXSTATUS_NONE     = 3'b000;
    localparam logic [2:0] RXSTATUS_DETECTED = 3'b011;

`ifdef PIPE_RATE_ACK_EN
    localparam logic [2:0] RATE_GEN1 = 3'd0;
`endif

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        PWR_CHG,
        DETECT
`ifdef PIPE_RATE_ACK_EN
        , RATE_CHG
`endif
    } phy_state_e;

    // P1 and P2 keep the transmitter parked in electrical idle.
    function automatic logic is_tx_off_state(input logic [3:0] ps);
        return (ps == P1) || (ps == P2);
    endfunction

endpackage

// File: rtl/pipe_lat_counter.sv
// Loadable down-counter shared by the reset, power, detect and standby timers.
// expire flags the last counted cycle (count == 1); zero flags an idle counter.
module pipe_lat_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(1));
    assign zero   = (cnt_q == '0);

endmodule

// File: rtl/pipe_phy_ctrl_responder.sv
// PHY-side PIPE control responder: PhyStatus/RxStatus handshakes, RxElecIdle, RxStandbyStatus.
// Build option PIPE_RATE_ACK_EN adds the Rate input and a rate-change acknowledge.
module pipe_phy_ctrl_responder
    import pipe_pkg::*;
#(
    parameter int unsigned RESET_LATENCY   = 8,
    parameter int unsigned PWR_LATENCY     = 4,
    parameter int unsigned DETECT_LATENCY  = 16,
    parameter int unsigned STANDBY_LATENCY = 2,
    parameter int unsigned CNT_W           = 5
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic [3:0] PowerDown,
    input  logic       TxDetectRx_Loopback,
    input  logic       TxElecIdle,
    input  logic       RxStandby,
    input  logic       rx_present,
    input  logic       link_idle,
`ifdef PIPE_RATE_ACK_EN
    input  logic [2:0] Rate,
`endif
    output logic       PhyStatus,
    output logic [2:0] RxStatus,
    output logic       RxElecIdle,
    output logic       RxStandbyStatus,
    output logic [3:0] PowerState,
    output logic       tx_line_idle,
    output logic       detect_busy
);

    // The reset timer is armed on the first cycle after release, hence one less.
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_LATENCY - 1);
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_LATENCY);
    localparam logic [CNT_W-1:0] DET_LOAD = CNT_W'(DETECT_LATENCY);
    localparam logic [CNT_W-1:0] SB_LOAD  = CNT_W'(STANDBY_LATENCY);

    phy_state_e       state_q, state_d;
    logic             phy_status_q, phy_status_d;
    logic [2:0]       rx_status_q, rx_status_d;
    logic             rx_elec_idle_q, rx_elec_idle_d;
    logic             rx_standby_status_q, rx_standby_status_d;
    logic [3:0]       power_state_q, power_state_d;
    logic [3:0]       target_q, target_d;
    logic             tx_line_idle_q, tx_line_idle_d;
    logic             detect_busy_q, detect_busy_d;
    logic             standby_prev_q, standby_prev_d;
    logic             standby_filt_q, standby_filt_d;
`ifdef PIPE_RATE_ACK_EN
    logic [2:0]       rate_q, rate_d;
    logic [2:0]       rate_tgt_q, rate_tgt_d;
`endif

    logic             lat_load;
    logic [CNT_W-1:0] lat_val;
    logic             lat_expire;
    logic             lat_zero;
    logic             sb_edge;
    logic             sb_expire;
    logic             sb_zero;

    pipe_lat_counter #(.CNT_W(CNT_W)) u_lat_ctr (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .load     (lat_load),
        .load_val (lat_val),
        .expire   (lat_expire),
        .zero     (lat_zero)
    );

    pipe_lat_counter #(.CNT_W(CNT_W)) u_sb_ctr (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .load     (sb_edge),
        .load_val (SB_LOAD),
        .expire   (sb_expire),
        .zero     (sb_zero)
    );

    always_comb begin
        state_d       = state_q;
        phy_status_d  = 1'b0;
        rx_status_d   = RXSTATUS_NONE;
        power_state_d = power_state_q;
        target_d      = target_q;
        detect_busy_d = detect_busy_q;
        lat_load      = 1'b0;
        lat_val       = '0;
`ifdef PIPE_RATE_ACK_EN
        rate_d        = rate_q;
        rate_tgt_d    = rate_tgt_q;
`endif
        case (state_q)
            RST_WAIT: begin
                phy_status_d = 1'b1;
                if (lat_zero) begin
                    lat_load = 1'b1;
                    lat_val  = RST_LOAD;
                end
                if (lat_expire) begin
                    phy_status_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            IDLE: begin
                if ((PowerDown != power_state_q) && (PowerDown <= P2)) begin
                    target_d = PowerDown;
                    state_d  = PWR_CHG;
                    lat_load = 1'b1;
                    lat_val  = PWR_LOAD;
                end else if (TxDetectRx_Loopback && (power_state_q == P1)) begin
                    detect_busy_d = 1'b1;
                    state_d       = DETECT;
                    lat_load      = 1'b1;
                    lat_val       = DET_LOAD;
`ifdef PIPE_RATE_ACK_EN
                end else if ((Rate != rate_q) &&
                             ((power_state_q == P0) || (power_state_q == P0S))) begin
                    rate_tgt_d = Rate;
                    state_d    = RATE_CHG;
                    lat_load   = 1'b1;
                    lat_val    = PWR_LOAD;
`endif
                end
            end
            PWR_CHG: begin
                if (lat_expire) begin
                    power_state_d = target_q;
                    phy_status_d  = 1'b1;
                    state_d       = IDLE;
                end
            end
            DETECT: begin
                // A dropped request abandons detection silently; it wins over expiry.
                if (!TxDetectRx_Loopback) begin
                    detect_busy_d = 1'b0;
                    state_d       = IDLE;
                end else if (lat_expire) begin
                    phy_status_d  = 1'b1;
                    rx_status_d   = rx_present ? RXSTATUS_DETECTED : RXSTATUS_NONE;
                    detect_busy_d = 1'b0;
                    state_d       = IDLE;
                end
            end
`ifdef PIPE_RATE_ACK_EN
            RATE_CHG: begin
                if (lat_expire) begin
                    rate_d       = rate_tgt_q;
                    phy_status_d = 1'b1;
                    state_d      = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rx_elec_idle_d = (power_state_q != P0) || link_idle;
        tx_line_idle_d = TxElecIdle || is_tx_off_state(power_state_q);
        standby_prev_d = RxStandby;
        sb_edge        = (RxStandby != standby_prev_q);
        standby_filt_d = standby_filt_q;
        // Settled means the last load has run out (or nothing is pending).
        if (!sb_edge && (sb_expire || sb_zero)) begin
            standby_filt_d = standby_prev_q;
        end
        rx_standby_status_d = (power_state_q == P0) && standby_filt_d;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= RST_WAIT;
            phy_status_q        <= 1'b1;
            rx_status_q         <= RXSTATUS_NONE;
            rx_elec_idle_q      <= 1'b1;
            rx_standby_status_q <= 1'b0;
            power_state_q       <= P1;
            target_q            <= P1;
            tx_line_idle_q      <= 1'b1;
            detect_busy_q       <= 1'b0;
            standby_prev_q      <= 1'b0;
            standby_filt_q      <= 1'b0;
`ifdef PIPE_RATE_ACK_EN
            rate_q              <= RATE_GEN1;
            rate_tgt_q          <= RATE_GEN1;
`endif
        end else begin
            state_q             <= state_d;
            phy_status_q        <= phy_status_d;
            rx_status_q         <= rx_status_d;
            rx_elec_idle_q      <= rx_elec_idle_d;
            rx_standby_status_q <= rx_standby_status_d;
            power_state_q       <= power_state_d;
            target_q            <= target_d;
            tx_line_idle_q      <= tx_line_idle_d;
            detect_busy_q       <= detect_busy_d;
            standby_prev_q      <= standby_prev_d;
            standby_filt_q      <= standby_filt_d;
`ifdef PIPE_RATE_ACK_EN
            rate_q              <= rate_d;
            rate_tgt_q          <= rate_tgt_d;
`endif
        end
    end

    assign PhyStatus       = phy_status_q;
    assign RxStatus        = rx_status_q;
    assign RxElecIdle      = rx_elec_idle_q;
    assign RxStandbyStatus = rx_standby_status_q;
    assign PowerState      = power_state_q;
    assign tx_line_idle    = tx_line_idle_q;
    assign detect_busy     = detect_busy_q;

endmodule

// File: tb/tb_pipe_phy_ctrl_responder.sv
// Randomized bench for pipe_phy_ctrl_responder against a deadline-based reference model.
module tb_pipe_phy_ctrl_responder;

    localparam int RL = 8;
    localparam int PL = 4;
    localparam int DL = 16;
    localparam int SL = 2;

    logic       pclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] PowerDown = 4'd2;
    logic       TxDetectRx_Loopback = 1'b0;
    logic       TxElecIdle = 1'b1;
    logic       RxStandby = 1'b0;
    logic       rx_present = 1'b0;
    logic       link_idle = 1'b1;
`ifdef PIPE_RATE_ACK_EN
    logic [2:0] Rate = 3'd0;
`endif
    logic       PhyStatus;
    logic [2:0] RxStatus;
    logic       RxElecIdle;
    logic       RxStandbyStatus;
    logic [3:0] PowerState;
    logic       tx_line_idle;
    logic       detect_busy;

    always #5 pclk = ~pclk;

    pipe_phy_ctrl_responder #(
        .RESET_LATENCY   (RL),
        .PWR_LATENCY     (PL),
        .DETECT_LATENCY  (DL),
        .STANDBY_LATENCY (SL),
        .CNT_W           (5)
    ) dut (
        .pclk                (pclk),
        .reset_n             (reset_n),
        .PowerDown           (PowerDown),
        .TxDetectRx_Loopback (TxDetectRx_Loopback),
        .TxElecIdle          (TxElecIdle),
        .RxStandby           (RxStandby),
        .rx_present          (rx_present),
        .link_idle           (link_idle),
`ifdef PIPE_RATE_ACK_EN
        .Rate                (Rate),
`endif
        .PhyStatus           (PhyStatus),
        .RxStatus            (RxStatus),
        .RxElecIdle          (RxElecIdle),
        .RxStandbyStatus     (RxStandbyStatus),
        .PowerState          (PowerState),
        .tx_line_idle        (tx_line_idle),
        .detect_busy         (detect_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycle index since release, pending job kind and its due cycle.
    int cyc;
    int m_ps;
    int job;        // 0 none, 1 power change, 2 receiver detection
    int job_end;
    int job_tgt;
    bit m_busy;
    bit m_filt;
    bit last_phy;
    bit sb_hist[$];

    task automatic model_reset();
        cyc = 0;
        m_ps = 2;
        job = 0;
        job_end = 0;
        job_tgt = 2;
        m_busy = 1'b0;
        m_filt = 1'b0;
        last_phy = 1'b1;
        sb_hist.delete();
        for (int i = 0; i <= SL; i++) sb_hist.push_back(1'b0);
    endtask

    task automatic check_reset_values();
        check_eq("rst_phystatus", 32'(PhyStatus), 32'd1);
        check_eq("rst_rxstatus", 32'(RxStatus), 32'd0);
        check_eq("rst_rxelecidle", 32'(RxElecIdle), 32'd1);
        check_eq("rst_standby", 32'(RxStandbyStatus), 32'd0);
        check_eq("rst_powerstate", 32'(PowerState), 32'd2);
        check_eq("rst_txlineidle", 32'(tx_line_idle), 32'd1);
        check_eq("rst_detectbusy", 32'(detect_busy), 32'd0);
    endtask

    task automatic tick();
        int prev_ps;
        bit e_phy;
        int e_rxs;
        bit all_eq;
        @(posedge pclk);
        #1;
        cyc++;
        prev_ps = m_ps;
        e_phy = 1'b0;
        e_rxs = 0;
        if (cyc <= RL) begin
            e_phy = (cyc < RL);
        end else if (job == 0) begin
            if ((int'(PowerDown) != m_ps) && (PowerDown <= 4'd3)) begin
                job = 1;
                job_end = cyc + PL;
                job_tgt = int'(PowerDown);
            end else if (TxDetectRx_Loopback && m_ps == 2) begin
                job = 2;
                job_end = cyc + DL;
                m_busy = 1'b1;
            end
        end else if (job == 1) begin
            if (cyc == job_end) begin
                m_ps = job_tgt;
                e_phy = 1'b1;
                job = 0;
            end
        end else begin
            if (!TxDetectRx_Loopback) begin
                job = 0;
                m_busy = 1'b0;
            end else if (cyc == job_end) begin
                e_phy = 1'b1;
                e_rxs = rx_present ? 3 : 0;
                m_busy = 1'b0;
                job = 0;
            end
        end
        sb_hist.push_back(RxStandby);
        void'(sb_hist.pop_front());
        all_eq = 1'b1;
        foreach (sb_hist[i]) if (sb_hist[i] != sb_hist[0]) all_eq = 1'b0;
        if (all_eq) m_filt = sb_hist[0];

        check_eq("phystatus", 32'(PhyStatus), 32'(e_phy));
        check_eq("rxstatus", 32'(RxStatus), 32'(e_rxs));
        check_eq("powerstate", 32'(PowerState), 32'(m_ps));
        check_eq("detect_busy", 32'(detect_busy), 32'(m_busy));
        check_eq("rxelecidle", 32'(RxElecIdle), 32'((prev_ps != 0) || link_idle));
        check_eq("tx_line_idle", 32'(tx_line_idle), 32'(TxElecIdle || prev_ps >= 2));
        check_eq("rxstandbystatus", 32'(RxStandbyStatus), 32'((prev_ps == 0) && m_filt));
        if (PhyStatus && cyc > RL) check_eq("phy_gap", 32'(last_phy), 32'd0);
        last_phy = PhyStatus;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_values();
        @(negedge pclk);
        reset_n = 1'b1;

        // Requests during the reset wait must be ignored.
        repeat (5) begin
            PowerDown = 4'($urandom_range(0, 15));
            TxDetectRx_Loopback = 1'($urandom_range(0, 1));
            tick();
        end
        PowerDown = 4'd2;
        TxDetectRx_Loopback = 1'b0;
        run(7);

        link_idle = 1'b0;
        PowerDown = 4'd0;
        run(8);
        RxStandby = 1'b1;
        run(6);
        RxStandby = 1'b0;
        run(1);
        RxStandby = 1'b1;
        run(5);
        link_idle = 1'b1;
        PowerDown = 4'd2;
        run(8);

        rx_present = 1'b1;
        TxDetectRx_Loopback = 1'b1;
        run(18);
        TxDetectRx_Loopback = 1'b0;
        run(3);
        rx_present = 1'b0;
        TxDetectRx_Loopback = 1'b1;
        run(40);
        rx_present = 1'b1;
        run(20);
        PowerDown = 4'd0;
        run(30);
        TxDetectRx_Loopback = 1'b0;

        PowerDown = 4'd2;
        run(8);
        TxDetectRx_Loopback = 1'b1;
        run(6);
        TxDetectRx_Loopback = 1'b0;
        run(4);
        PowerDown = 4'd7;
        run(10);
        PowerDown = 4'd0;
        run(8);
        PowerDown = 4'd15;
        run(8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                PowerDown = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15))
                                                         : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) TxDetectRx_Loopback = ~TxDetectRx_Loopback;
            if ($urandom_range(0, 7) == 0) rx_present = 1'($urandom_range(0, 1));
            link_idle = ($urandom_range(0, 3) == 0);
            TxElecIdle = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) RxStandby = ~RxStandby;
            tick();
        end

        // Asynchronous reset in the middle of a power change.
        TxDetectRx_Loopback = 1'b0;
        run(25);
        PowerDown = 4'((m_ps + 1) % 4);
        run(2);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        PowerDown = 4'd2;
        @(negedge pclk);
        reset_n = 1'b1;
        run(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
